level_processor: RTL and testbench

- Upstream stage of the display controller. It samples the raw liquid-level word and checks it and the alarm thresholds for validity.
- It computes the at/above-upper (GOET) and at/below-lower (LOET) alarm flags.
- It converts the level to three BCD digits with a sequential double-dabble engine.
- All outputs update together at the end of each conversion and drive data_h/data_t/data_u, GOET, LOET and input_error of the display controller directly.

---
 rtl/lvl_pkg.sv | 22 ++
 rtl/bin2bcd_seq.sv | 57 +++++
 rtl/level_processor.sv | 121 ++++++++++++
 tb/tb_level_processor.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/lvl_pkg.sv
// Shared types and constants for the level processing slice:
// FSM state encoding, BCD geometry and the double-dabble nibble adjust.
package lvl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    UPDATE = 2'd2
  } lvl_state_e;

  localparam int BCD_DIGITS    = 3;
  localparam int NIBBLE_W      = 4;
  localparam int BCD_W         = BCD_DIGITS * NIBBLE_W;
  localparam int MAX_LEVEL_DEF = 999;

  function automatic logic [NIBBLE_W-1:0] add3(
    input logic [NIBBLE_W-1:0] n
  );
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble: one adjust+shift per clock, WIDTH clocks.
// Ports: clk_100MHz, reset, start, bin, done (1-cycle pulse), bcd.
module bin2bcd_seq
  import lvl_pkg::*;
#(
  parameter int WIDTH = 10
) (
  input  logic             clk_100MHz,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] bin,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);

  localparam int SW = BCD_W + WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  logic [SW-1:0] sh_q;
  logic [SW-1:0] adj;
  logic [CW-1:0] cnt_q;
  logic          run_q;

  always_comb begin
    adj = sh_q;
    for (int d = 0; d < BCD_DIGITS; d++) begin
      adj[WIDTH+NIBBLE_W*d +: NIBBLE_W] =
        add3(sh_q[WIDTH+NIBBLE_W*d +: NIBBLE_W]);
    end
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      sh_q  <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        sh_q  <= {{BCD_W{1'b0}}, bin};
        cnt_q <= '0;
        run_q <= 1'b1;
      end else if (run_q) begin
        sh_q  <= {adj[SW-2:0], 1'b0};
        cnt_q <= cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          run_q <= 1'b0;
          done  <= 1'b1;
        end
      end
    end
  end

  assign bcd = sh_q[SW-1:WIDTH];

endmodule

// File: rtl/level_processor.sv
// Samples the level, validates it against the thresholds, converts to BCD.
// Ports: clk_100MHz, reset, sample_en, level_raw, thr_hi, thr_lo in;
// data_h/t/u, GOET, LOET, input_error, busy, valid out (all registered).
module level_processor
  import lvl_pkg::*;
#(
  parameter int WIDTH     = 10,
  parameter int MAX_LEVEL = MAX_LEVEL_DEF
) (
  input  logic             clk_100MHz,
  input  logic             reset,
  input  logic             sample_en,
  input  logic [WIDTH-1:0] level_raw,
  input  logic [WIDTH-1:0] thr_hi,
  input  logic [WIDTH-1:0] thr_lo,
  output logic [3:0]       data_h,
  output logic [3:0]       data_t,
  output logic [3:0]       data_u,
  output logic             GOET,
  output logic             LOET,
  output logic             input_error,
  output logic             busy,
  output logic             valid
);

  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_LEVEL);

  lvl_state_e       state_q, state_d;
  logic             start;
  logic             do_update;
  logic             conv_done;
  logic [BCD_W-1:0] bcd;
  logic [WIDTH-1:0] lvl_q, hi_q, lo_q;
  logic             err;

  bin2bcd_seq #(
    .WIDTH(WIDTH)
  ) u_bcd (
    .clk_100MHz(clk_100MHz),
    .reset     (reset),
    .start     (start),
    .bin       (level_raw),
    .done      (conv_done),
    .bcd       (bcd)
  );

  always_ff @(posedge clk_100MHz) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    start     = 1'b0;
    do_update = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sample_en) begin
          start   = 1'b1;
          state_d = CONV;
        end
      end
      CONV: begin
        if (conv_done) state_d = UPDATE;
      end
      UPDATE: begin
        do_update = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Snapshot frozen for the whole conversion; live inputs are ignored.
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      lvl_q <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else if (start) begin
      lvl_q <= level_raw;
      hi_q  <= thr_hi;
      lo_q  <= thr_lo;
    end
  end

  // lo < hi guarantees GOET and LOET can never be set together.
  assign err = (lvl_q > MAX_W) || (lo_q >= hi_q);

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      data_h      <= '0;
      data_t      <= '0;
      data_u      <= '0;
      GOET        <= 1'b0;
      LOET        <= 1'b0;
      input_error <= 1'b0;
      busy        <= 1'b0;
      valid       <= 1'b0;
    end else begin
      valid <= do_update;
      if (start) busy <= 1'b1;
      if (do_update) begin
        busy <= 1'b0;
        if (err) begin
          GOET        <= 1'b0;
          LOET        <= 1'b0;
          input_error <= 1'b1;
        end else begin
          data_h      <= bcd[11:8];
          data_t      <= bcd[7:4];
          data_u      <= bcd[3:0];
          GOET        <= lvl_q >= hi_q;
          LOET        <= lvl_q <= lo_q;
          input_error <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_level_processor.sv
// Self-checking bench for level_processor: timing-level reference
// model compared every cycle, plus directed literal expectations.
module tb_level_processor;

  localparam int W   = 10;
  localparam int LAT = W + 2;

  logic         clk_100MHz = 1'b0;
  logic         reset      = 1'b1;
  logic         sample_en  = 1'b0;
  logic [W-1:0] level_raw  = '0;
  logic [W-1:0] thr_hi     = '0;
  logic [W-1:0] thr_lo     = '0;
  logic [3:0]   data_h, data_t, data_u;
  logic         GOET, LOET, input_error, busy, valid;

  level_processor #(.WIDTH(W), .MAX_LEVEL(999)) dut (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .sample_en  (sample_en),
    .level_raw  (level_raw),
    .thr_hi     (thr_hi),
    .thr_lo     (thr_lo),
    .data_h     (data_h),
    .data_t     (data_t),
    .data_u     (data_u),
    .GOET       (GOET),
    .LOET       (LOET),
    .input_error(input_error),
    .busy       (busy),
    .valid      (valid)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Reference model: a conversion is a countdown of LAT edges
  // after acceptance; results follow the arithmetic rules.
  int m_rem = 0;
  int m_lvl, m_hi, m_lo;
  int m_h = 0, m_t = 0, m_u = 0;
  bit m_goet = 0, m_loet = 0, m_err = 0, m_busy = 0, m_valid = 0;

  always @(posedge clk_100MHz) begin
    cyc <= cyc + 1;
    if (reset) begin
      m_rem <= 0; m_busy <= 0; m_valid <= 0;
      m_h <= 0; m_t <= 0; m_u <= 0;
      m_goet <= 0; m_loet <= 0; m_err <= 0;
    end else begin
      m_valid <= 0;
      if (m_busy) begin
        m_rem <= m_rem - 1;
        if (m_rem == 1) begin
          m_busy  <= 0;
          m_valid <= 1;
          if (m_lvl > 999 || m_lo >= m_hi) begin
            m_err <= 1; m_goet <= 0; m_loet <= 0;
          end else begin
            m_err  <= 0;
            m_h    <= m_lvl / 100;
            m_t    <= (m_lvl / 10) % 10;
            m_u    <= m_lvl % 10;
            m_goet <= m_lvl >= m_hi;
            m_loet <= m_lvl <= m_lo;
          end
        end
      end else if (sample_en) begin
        m_busy <= 1;
        m_rem  <= LAT;
        m_lvl  <= int'(level_raw);
        m_hi   <= int'(thr_hi);
        m_lo   <= int'(thr_lo);
      end
    end
  end

  always @(negedge clk_100MHz) begin
    if (cyc > 0) begin
      check("busy", int'(busy), int'(m_busy));
      check("valid", int'(valid), int'(m_valid));
      check("digits", int'({data_h, data_t, data_u}),
            m_h * 256 + m_t * 16 + m_u);
      check("goet", int'(GOET), int'(m_goet));
      check("loet", int'(LOET), int'(m_loet));
      check("err", int'(input_error), int'(m_err));
    end
  end

  task automatic set_in(int l, int h, int lo);
    level_raw = W'(l);
    thr_hi    = W'(h);
    thr_lo    = W'(lo);
  endtask

  task automatic wait_valid(input int e);
    bit seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk_100MHz);
      if (valid === 1'b1) seen = 1;
    end
    check("valid_seen", int'(seen), 1);
    if (seen) check("latency", cyc - e, LAT);
  endtask

  task automatic conv(int l, int h, int lo);
    int e;
    @(posedge clk_100MHz); #2;
    set_in(l, h, lo);
    sample_en = 1'b1;
    @(posedge clk_100MHz); #2;
    e = cyc;
    sample_en = 1'b0;
    wait_valid(e);
  endtask

  task automatic do_reset();
    @(posedge clk_100MHz); #2;
    reset = 1'b1;
    @(posedge clk_100MHz); #2;
    reset = 1'b0;
  endtask

  task automatic check_lit(string n, int h, int t, int u,
                           int g, int l, int er);
    check({n, "_h"}, int'(data_h), h);
    check({n, "_t"}, int'(data_t), t);
    check({n, "_u"}, int'(data_u), u);
    check({n, "_goet"}, int'(GOET), g);
    check({n, "_loet"}, int'(LOET), l);
    check({n, "_err"}, int'(input_error), er);
  endtask

  initial begin
    int e;
    repeat (2) @(posedge clk_100MHz);
    #2 reset = 1'b0;
    @(negedge clk_100MHz);
    check_lit("rst", 0, 0, 0, 0, 0, 0);
    check("rst_busy", int'(busy), 0);

    conv(537, 800, 100);
    check_lit("t1", 5, 3, 7, 0, 0, 0);
    @(negedge clk_100MHz);
    check("t1_pulse", int'(valid), 0);

    conv(800, 800, 100);
    check_lit("t2a", 8, 0, 0, 1, 0, 0);
    conv(100, 800, 100);
    check_lit("t2b", 1, 0, 0, 0, 1, 0);

    conv(42, 800, 100);
    conv(1000, 800, 100);
    check_lit("t3a", 0, 4, 2, 0, 0, 1);
    conv(300, 500, 500);
    check_lit("t3b", 0, 4, 2, 0, 0, 1);
    conv(999, 800, 100);
    check_lit("t3c", 9, 9, 9, 1, 0, 0);

    // Pulse during busy is dropped; pulse in the valid cycle is taken.
    @(posedge clk_100MHz); #2;
    set_in(123, 800, 100);
    sample_en = 1'b1;
    @(posedge clk_100MHz); #2;
    e = cyc;
    sample_en = 1'b0;
    repeat (2) @(posedge clk_100MHz);
    #2 set_in(999, 800, 100);
    sample_en = 1'b1;
    @(posedge clk_100MHz); #2;
    sample_en = 1'b0;
    wait_valid(e);
    check_lit("t4a", 1, 2, 3, 0, 0, 0);
    #1 sample_en = 1'b1;
    @(posedge clk_100MHz); #2;
    e = cyc;
    sample_en = 1'b0;
    wait_valid(e);
    check_lit("t4b", 9, 9, 9, 1, 0, 0);

    // Reset mid-conversion aborts without a valid pulse.
    @(posedge clk_100MHz); #2;
    set_in(250, 800, 100);
    sample_en = 1'b1;
    @(posedge clk_100MHz); #2;
    sample_en = 1'b0;
    repeat (5) @(posedge clk_100MHz);
    #2 reset = 1'b1;
    @(posedge clk_100MHz); #2;
    reset = 1'b0;
    @(negedge clk_100MHz);
    check_lit("t5", 0, 0, 0, 0, 0, 0);
    check("t5_busy", int'(busy), 0);
    repeat (LAT + 2) @(negedge clk_100MHz);
    conv(250, 800, 100);
    check_lit("t5b", 2, 5, 0, 0, 0, 0);

    for (int i = 0; i < 1000; i++) begin
      conv(i, 999, 0);
      if (i == 0)   check_lit("sw0", 0, 0, 0, 0, 1, 0);
      if (i == 500) check_lit("sw500", 5, 0, 0, 0, 0, 0);
      if (i == 999) check_lit("sw999", 9, 9, 9, 1, 0, 0);
    end

    for (int k = 0; k < 4000; k++) begin
      @(posedge clk_100MHz); #2;
      sample_en = ($urandom_range(0, 5) == 0);
      level_raw = W'($urandom_range(0, 1023));
      thr_hi    = W'($urandom_range(0, 1023));
      thr_lo    = W'($urandom_range(0, 1023));
      reset     = ($urandom_range(0, 399) == 0);
    end
    @(posedge clk_100MHz); #2;
    sample_en = 1'b0;
    reset     = 1'b0;
    repeat (LAT + 4) @(posedge clk_100MHz);
    @(negedge clk_100MHz);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
